ram_xfer_seq_ctrl: RTL and testbench

- Sequencer for the two-RAM byte datapath: fills RAM A from the 8-bit input stream, copies RAM A into RAM B, then drains RAM B to the output port.
- Generates all RAM addresses, read/write enables and output-valid strobes.
- Sits beside the RAM A/RAM B pair inside the top level. The top level's input data bus feeds RAM A directly; this block only controls timing.

---
 rtl/ram_xfer_seq_ctrl.sv | 100 ++++++++++
 tb/tb_ram_xfer_seq_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_xfer_seq_ctrl.sv
// ram_xfer_seq_ctrl: sequences fill, copy and drain of the two-RAM byte datapath
module ram_xfer_seq_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stall,
  output logic              ram_a_we,
  output logic              ram_a_re,
  output logic [ADDR_W-1:0] ram_a_addr,
  output logic              ram_b_we,
  output logic              ram_b_re,
  output logic [ADDR_W-1:0] ram_b_addr,
  output logic              out_valid,
  output logic              busy,
  output logic              done,
  output logic [1:0]        phase
);
  typedef enum logic [2:0] {IDLE, FILL, COPY, DRAIN, DONE_ST} state_t;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH);
  state_t            st, st_n;
  logic [ADDR_W:0]   cnt, cnt_n, base;
  logic              iss, a_we_n, a_re_n, b_we_n, b_re_n, ov_n, done_n, busy_n;
  logic [ADDR_W-1:0] a_addr_n, b_addr_n;
  logic [1:0]        phase_n;
  // Next state plus the registered image of every output for the coming cycle;
  // the lag stage (b_we/out_valid) retires regardless of stall.
  always_comb begin
    st_n = st;
    base = cnt;
    b_we_n = 1'b0;
    ov_n = 1'b0;
    b_addr_n = ram_b_addr;
    case (st)
      IDLE: if (start) begin
        st_n = FILL;
        base = '0;
      end
      FILL: if (cnt == LAST && !stall) begin
        st_n = COPY;
        base = '0;
      end
      COPY: begin
        b_we_n = ram_a_re;
        b_addr_n = ram_a_re ? ram_a_addr : ram_b_addr;
        if (cnt == LAST && !ram_a_re && !stall) begin
          st_n = DRAIN;
          base = '0;
        end
      end
      DRAIN: begin
        ov_n = ram_b_re;
        if (cnt == LAST && !ram_b_re && !stall) st_n = DONE_ST;
      end
      default: st_n = IDLE;
    endcase
    iss = !stall && base != LAST && (st_n == FILL || st_n == COPY || st_n == DRAIN);
    cnt_n = base + (ADDR_W+1)'(iss);
    a_we_n = iss && st_n == FILL;
    a_re_n = iss && st_n == COPY;
    b_re_n = iss && st_n == DRAIN;
    a_addr_n = (a_we_n || a_re_n) ? base[ADDR_W-1:0] : ram_a_addr;
    if (b_re_n) b_addr_n = base[ADDR_W-1:0];
    done_n = st_n == DONE_ST;
    phase_n = st_n == FILL ? 2'd1 : st_n == COPY ? 2'd2 : st_n == DRAIN ? 2'd3 : 2'd0;
    busy_n = phase_n != 2'd0;
  end
  // State, counter and output registers; reset clears all of them immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st <= IDLE;
      cnt <= '0;
      ram_a_we <= 1'b0;
      ram_a_re <= 1'b0;
      ram_a_addr <= '0;
      ram_b_we <= 1'b0;
      ram_b_re <= 1'b0;
      ram_b_addr <= '0;
      out_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      phase <= 2'd0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      ram_a_we <= a_we_n;
      ram_a_re <= a_re_n;
      ram_a_addr <= a_addr_n;
      ram_b_we <= b_we_n;
      ram_b_re <= b_re_n;
      ram_b_addr <= b_addr_n;
      out_valid <= ov_n;
      busy <= busy_n;
      done <= done_n;
      phase <= phase_n;
    end
  end
endmodule

// File: tb/tb_ram_xfer_seq_ctrl.sv
// tb_ram_xfer_seq_ctrl: randomized bench with a progress-count reference model and RAM models
module tb_ram_xfer_seq_ctrl;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  logic clk, reset_n, start, stall;
  logic ram_a_we, ram_a_re, ram_b_we, ram_b_re, out_valid, busy, done;
  logic [ADDR_W-1:0] ram_a_addr, ram_b_addr;
  logic [1:0] phase;
  logic [7:0] din, rd_a, rd_b;
  logic [7:0] mem_a [DEPTH];
  logic [7:0] mem_b [DEPTH];
  int total, bad;

  ram_xfer_seq_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stall(stall),
    .ram_a_we(ram_a_we), .ram_a_re(ram_a_re), .ram_a_addr(ram_a_addr),
    .ram_b_we(ram_b_we), .ram_b_re(ram_b_re), .ram_b_addr(ram_b_addr),
    .out_valid(out_valid), .busy(busy), .done(done), .phase(phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM pair of the datapath, both with one-cycle read latency
  always @(posedge clk) begin
    if (ram_a_we) mem_a[ram_a_addr] <= din;
    if (ram_a_re) rd_a <= mem_a[ram_a_addr];
    if (ram_b_we) mem_b[ram_b_addr] <= rd_a;
    if (ram_b_re) rd_b <= mem_b[ram_b_addr];
  end

  // Model: the sequence is 3*DEPTH+3 progress steps from the START edge. A step
  // happens on every unstalled edge, and also on a stalled edge right after the
  // final read of COPY or DRAIN (the lag retires anyway). Step p selects phase,
  // enables and addresses arithmetically.
  task automatic run_seq(input string name, input int pct, input int s_at, input int s_len,
                         input bit poke, output int dcyc);
    logic [7:0] bytes [DEPTH];
    logic [8:0] ev, av;
    int p, n, ph, pai, pbi;
    bit s, ea, er, ew, ebr, eov, ed, pa, pb;
    for (int i = 0; i < DEPTH; i++) bytes[i] = 8'($urandom);
    p = 0; n = 0; pa = 0; pb = 0; pai = 0; pbi = 0; dcyc = -1;
    @(negedge clk);
    start = 1'b1;
    while (dcyc < 0 && n < 400) begin
      n++;
      s = (n >= s_at && n < s_at + s_len) || ($urandom_range(99) < pct);
      stall = s;
      @(posedge clk);
      if (!s || p == 2*DEPTH || p == 3*DEPTH+1) p++;
      ph = p <= DEPTH ? 1 : p <= 2*DEPTH+1 ? 2 : p <= 3*DEPTH+2 ? 3 : 0;
      ea = !s && ph == 1;
      er = !s && ph == 2 && p <= 2*DEPTH;
      ebr = !s && ph == 3 && p <= 3*DEPTH+1;
      ew = pa;
      eov = pb;
      ed = p == 3*DEPTH+3;
      @(negedge clk);
      ev = {ea, er, ew, ebr, eov, ph != 0, ed, 2'(ph)};
      av = {ram_a_we, ram_a_re, ram_b_we, ram_b_re, out_valid, busy, done, phase};
      total++;
      if (av !== ev) begin
        bad++;
        $display("FAIL %s ctl n=%0d got=%b want=%b (we_a re_a we_b re_b ov busy done phase)", name, n, av, ev);
      end
      if (ea || er) begin
        total++;
        if (ram_a_addr !== ADDR_W'(ea ? p-1 : p-DEPTH-1)) begin
          bad++;
          $display("FAIL %s addr_a n=%0d got=%0d want=%0d", name, n, ram_a_addr, ea ? p-1 : p-DEPTH-1);
        end
      end
      if (ew || ebr) begin
        total++;
        if (ram_b_addr !== ADDR_W'(ew ? pai : p-2*DEPTH-2)) begin
          bad++;
          $display("FAIL %s addr_b n=%0d got=%0d want=%0d", name, n, ram_b_addr, ew ? pai : p-2*DEPTH-2);
        end
      end
      if (eov) begin
        total++;
        if (rd_b !== bytes[pbi]) begin
          bad++;
          $display("FAIL %s data n=%0d idx=%0d got=%h want=%h", name, n, pbi, rd_b, bytes[pbi]);
        end
      end
      pa = er; pai = p-DEPTH-1; pb = ebr; pbi = p-2*DEPTH-2;
      din = ea ? bytes[p-1] : 8'($urandom);
      start = poke && $urandom_range(9) == 0;
      if (ed) dcyc = n;
    end
    start = 1'b0;
    stall = 1'b0;
    if (dcyc < 0) begin
      total++;
      bad++;
      $display("FAIL %s timeout got=no_done want=done_within_400", name);
    end
    @(posedge clk);
    @(negedge clk);
    total++;
    av = {ram_a_we, ram_a_re, ram_b_we, ram_b_re, out_valid, busy, done, phase};
    if (av !== 9'd0) begin
      bad++;
      $display("FAIL %s idle_after got=%b want=%b", name, av, 9'd0);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; stall = 1'b0; din = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({ram_a_we, ram_a_re, ram_b_we, ram_b_re, out_valid, busy, done, phase, ram_a_addr, ram_b_addr} !== 17'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=0", {ram_a_we, ram_a_re, ram_b_we, ram_b_re, out_valid, busy, done, phase, ram_a_addr, ram_b_addr});
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, done, phase, ram_a_we} !== 5'd0) begin
      bad++;
      $display("FAIL reset_idle got=%b want=0", {busy, done, phase, ram_a_we});
    end
  endtask

  task automatic test_nominal();
    int d;
    run_seq("nominal", 0, 0, 0, 1'b0, d);
    total++;
    if (d !== 3*DEPTH+3) begin bad++; $display("FAIL nominal_done_cycle got=%0d want=%0d", d, 3*DEPTH+3); end
  endtask

  task automatic test_stall_copy();
    int d;
    run_seq("stall_copy", 0, 22, 3, 1'b0, d);
    total++;
    if (d !== 3*DEPTH+6) begin bad++; $display("FAIL stall_copy_done_cycle got=%0d want=%0d", d, 3*DEPTH+6); end
  endtask

  task automatic test_start_with_stall();
    int d;
    run_seq("start_stall", 0, 1, 2, 1'b0, d);
    total++;
    if (d !== 3*DEPTH+5) begin bad++; $display("FAIL start_stall_done_cycle got=%0d want=%0d", d, 3*DEPTH+5); end
  endtask

  task automatic test_start_ignored();
    int d;
    run_seq("start_ignored", 0, 0, 0, 1'b1, d);
    total++;
    if (d !== 3*DEPTH+3) begin bad++; $display("FAIL start_ignored_done_cycle got=%0d want=%0d", d, 3*DEPTH+3); end
  endtask

  task automatic test_random();
    int d;
    for (int r = 0; r < 4; r++) run_seq("random", 15 + 10*r, 0, 0, 1'b1, d);
  endtask

  task automatic test_abort();
    int d;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (24) @(posedge clk);
    #1;
    total++;
    if (phase !== 2'd2) begin bad++; $display("FAIL abort_pre_phase got=%0d want=2", phase); end
    #1 reset_n = 1'b0;
    #1;
    total++;
    if ({ram_a_we, ram_a_re, ram_b_we, ram_b_re, out_valid, busy, done, phase, ram_a_addr, ram_b_addr} !== 17'd0) begin
      bad++;
      $display("FAIL abort_async got=%b want=0", {ram_a_we, ram_a_re, ram_b_we, ram_b_re, out_valid, busy, done, phase, ram_a_addr, ram_b_addr});
    end
    @(posedge clk);
    #1;
    total++;
    if ({ram_a_re, ram_b_we, busy, phase} !== 5'd0) begin
      bad++;
      $display("FAIL abort_held got=%b want=0", {ram_a_re, ram_b_we, busy, phase});
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, done, phase} !== 4'd0) begin bad++; $display("FAIL abort_idle got=%b want=0", {busy, done, phase}); end
    run_seq("after_abort", 0, 0, 0, 1'b0, d);
    total++;
    if (d !== 3*DEPTH+3) begin bad++; $display("FAIL after_abort_done_cycle got=%0d want=%0d", d, 3*DEPTH+3); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_nominal();
    test_stall_copy();
    test_start_with_stall();
    test_start_ignored();
    test_random();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
